// File: rtl/cpu_mem_bridge.sv
// Strobe-bus to single-port sync RAM bridge: edge-started accesses, 2+WAIT_STATES cycle latency, ready flag.
// Optional VECTOR_OVERLAY_EN: reads of FFFE/FFFF return RESET_VECTOR bytes without touching RAM.
module cpu_mem_bridge #(
  parameter int          ADDR_W       = 16,
  parameter int          WAIT_STATES  = 0,
  parameter logic [15:0] RESET_VECTOR = 16'h1000
) (
  input  logic              cpu_clk,
  input  logic              cpu_reset,
  input  logic [15:0]       cpu_addr_i,
  input  logic              cpu_oe_i,
  input  logic              cpu_we_i,
  input  logic [7:0]        cpu_data_i,
  output logic [7:0]        cpu_data_o,
  output logic              cpu_ready_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic       oe_q, we_q;
  logic       wr_q;
  logic       oe_rise, we_rise, start;
  logic       vec_hit;
  logic [7:0] rd_byte;

  assign oe_rise = cpu_oe_i & ~oe_q;
  assign we_rise = cpu_we_i & ~we_q;
  assign start   = (state_q == S_IDLE) & (oe_rise | we_rise);

`ifdef VECTOR_OVERLAY_EN
  logic vec_q, vec_lo_q;

  // Only reads are redirected; writes to FFFE/FFFF still reach RAM.
  assign vec_hit = ~we_rise & (cpu_addr_i[15:1] == 15'h7FFF);
  assign rd_byte = vec_q ? (vec_lo_q ? RESET_VECTOR[7:0] : RESET_VECTOR[15:8]) : ram_rdata_i;

  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      vec_q    <= 1'b0;
      vec_lo_q <= 1'b0;
    end else if (start) begin
      vec_q    <= vec_hit;
      vec_lo_q <= cpu_addr_i[0];
    end
  end
`else
  assign vec_hit = 1'b0;
  assign rd_byte = ram_rdata_i;
`endif

  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_ISSUE;
      S_ISSUE:   state_d = (cnt_q != 4'd0) ? S_WAIT : S_CAPTURE;
      S_WAIT:    if (cnt_q == 4'd1) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Strobe history resets high so a strobe already asserted at reset release is not an edge.
  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      cpu_data_o  <= 8'h00;
      cpu_ready_o <= 1'b1;
      ram_addr_o  <= '0;
      ram_en_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_wdata_o <= 8'h00;
    end else begin
      oe_q     <= cpu_oe_i;
      we_q     <= cpu_we_i;
      ram_en_o <= 1'b0;
      ram_we_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ram_addr_o  <= cpu_addr_i[ADDR_W-1:0];
            ram_wdata_o <= cpu_data_i;
            ram_en_o    <= ~vec_hit;
            ram_we_o    <= we_rise;
            wr_q        <= we_rise;
            cpu_ready_o <= 1'b0;
            cnt_q       <= 4'(WAIT_STATES);
          end
        end
        S_WAIT: cnt_q <= cnt_q - 4'd1;
        S_CAPTURE: begin
          if (!wr_q) cpu_data_o <= rd_byte;
          cpu_ready_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Bench for cpu_mem_bridge: two instances (0 and 3 wait states) share stimulus; table, corner sequences, random accesses vs a memory model.
module tb_cpu_mem_bridge;

  localparam int          WS0 = 0;
  localparam int          WS1 = 3;
  localparam logic [15:0] RV  = 16'h1000;
`ifdef VECTOR_OVERLAY_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  localparam logic [7:0] E_FE  = OVL ? 8'h10 : 8'hA5;
  localparam logic [7:0] E_FF  = OVL ? 8'h00 : 8'h3C;
  localparam logic [7:0] E_FE2 = OVL ? 8'h10 : 8'h77;

  logic            clk = 1'b0;
  logic            rst;
  logic [15:0]     addr;
  logic            oe, we;
  logic [7:0]      din;
  logic [1:0]      rdy, en, rwe;
  logic [1:0][15:0] raddr;
  logic [1:0][7:0] wdat, rdat, dout;

  logic [7:0] mem0 [65536];
  logic [7:0] mem1 [65536];
  logic [7:0] model_mem [65536];
  logic [7:0] model_dout;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl [9];

  always #5 clk = ~clk;

  cpu_mem_bridge #(.ADDR_W(16), .WAIT_STATES(WS0), .RESET_VECTOR(RV)) dut0 (
    .cpu_clk(clk), .cpu_reset(rst), .cpu_addr_i(addr), .cpu_oe_i(oe), .cpu_we_i(we),
    .cpu_data_i(din), .cpu_data_o(dout[0]), .cpu_ready_o(rdy[0]), .ram_addr_o(raddr[0]),
    .ram_en_o(en[0]), .ram_we_o(rwe[0]), .ram_wdata_o(wdat[0]), .ram_rdata_i(rdat[0]));

  cpu_mem_bridge #(.ADDR_W(16), .WAIT_STATES(WS1), .RESET_VECTOR(RV)) dut1 (
    .cpu_clk(clk), .cpu_reset(rst), .cpu_addr_i(addr), .cpu_oe_i(oe), .cpu_we_i(we),
    .cpu_data_i(din), .cpu_data_o(dout[1]), .cpu_ready_o(rdy[1]), .ram_addr_o(raddr[1]),
    .ram_en_o(en[1]), .ram_we_o(rwe[1]), .ram_wdata_o(wdat[1]), .ram_rdata_i(rdat[1]));

  // Synchronous single-port RAMs, read data valid the cycle after enable.
  always @(posedge clk) begin
    if (en[0]) begin
      if (rwe[0]) mem0[raddr[0]] <= wdat[0];
      else        rdat[0] <= mem0[raddr[0]];
    end
    if (en[1]) begin
      if (rwe[1]) mem1[raddr[1]] <= wdat[1];
      else        rdat[1] <= mem1[raddr[1]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_read(input logic [15:0] a);
    if (OVL && a[15:1] == 15'h7FFF) return a[0] ? RV[7:0] : RV[15:8];
    return model_mem[a];
  endfunction

  task automatic chk_reset(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s dout%0d", nm, k), 32'(dout[k]), 32'h00);
      chk($sformatf("%s rdy%0d", nm, k), 32'(rdy[k]), 32'h1);
      chk($sformatf("%s en%0d", nm, k), 32'(en[k]), 32'h0);
      chk($sformatf("%s we%0d", nm, k), 32'(rwe[k]), 32'h0);
      chk($sformatf("%s addr%0d", nm, k), 32'(raddr[k]), 32'h0);
      chk($sformatf("%s wdata%0d", nm, k), 32'(wdat[k]), 32'h0);
    end
  endtask

  // One access seen from both instances over a 10-cycle window after the start edge.
  task automatic do_access(input bit wr, input bit rd, input logic [15:0] a, input logic [7:0] wd,
                           input logic [7:0] exp, input bit collide, input string nm);
    int          lowc [2];
    int          enc  [2];
    logic [15:0] ea   [2];
    logic        ewe  [2];
    logic [7:0]  ewd  [2];
    bit          ovl;
    int          ws;
    ovl = OVL && !wr && (a[15:1] == 15'h7FFF);
    for (int k = 0; k < 2; k++) begin
      lowc[k] = 0; enc[k] = 0; ea[k] = '0; ewe[k] = 1'b0; ewd[k] = '0;
    end
    @(negedge clk);
    addr = a; din = wd; oe = rd; we = wr;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rdy[k]) lowc[k]++;
        if (en[k]) begin
          enc[k]++; ea[k] = raddr[k]; ewe[k] = rwe[k]; ewd[k] = wdat[k];
        end
      end
      if (i == 0) begin
        addr = 16'($urandom); din = 8'($urandom);
      end
      if (collide && i == 1) we = 1'b1;
    end
    oe = 1'b0; we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ws = (k == 0) ? WS0 : WS1;
      chk($sformatf("%s lat%0d", nm, k), 32'(lowc[k]), 32'(2 + ws));
      chk($sformatf("%s en_cnt%0d", nm, k), 32'(enc[k]), ovl ? 32'd0 : 32'd1);
      if (!ovl) begin
        chk($sformatf("%s ram_addr%0d", nm, k), 32'(ea[k]), 32'(a));
        chk($sformatf("%s ram_we%0d", nm, k), 32'(ewe[k]), 32'(wr));
        if (wr) chk($sformatf("%s ram_wdata%0d", nm, k), 32'(ewd[k]), 32'(wd));
      end
      chk($sformatf("%s dout%0d", nm, k), 32'(dout[k]), 32'(exp));
    end
    if (wr) model_mem[a] = wd;
    model_dout = exp;
  endtask

  initial begin
    int          lowc, enc;
    bit          wr;
    logic [15:0] a;
    logic [7:0]  wd;

    rst = 1'b1; oe = 1'b0; we = 1'b0; addr = '0; din = '0;
    for (int i = 0; i < 65536; i++) begin
      mem0[i] = 8'h00; mem1[i] = 8'h00; model_mem[i] = 8'h00;
    end
    mem0[16'h1000] = 8'h8E; mem1[16'h1000] = 8'h8E; model_mem[16'h1000] = 8'h8E;
    mem0[16'hFFFE] = 8'hA5; mem1[16'hFFFE] = 8'hA5; model_mem[16'hFFFE] = 8'hA5;
    mem0[16'hFFFF] = 8'h3C; mem1[16'hFFFF] = 8'h3C; model_mem[16'hFFFF] = 8'h3C;
    model_dout = 8'h00;

    tbl[0] = '{1'b0, 1'b1, 16'h1000, 8'h00, 8'h8E};
    tbl[1] = '{1'b1, 1'b0, 16'h0102, 8'h01, 8'h8E};
    tbl[2] = '{1'b0, 1'b1, 16'h0102, 8'h00, 8'h01};
    tbl[3] = '{1'b0, 1'b1, 16'hFFFE, 8'h00, E_FE};
    tbl[4] = '{1'b0, 1'b1, 16'hFFFF, 8'h00, E_FF};
    tbl[5] = '{1'b1, 1'b0, 16'hFFFE, 8'h77, E_FF};
    tbl[6] = '{1'b0, 1'b1, 16'hFFFE, 8'h00, E_FE2};
    tbl[7] = '{1'b1, 1'b1, 16'h2000, 8'h5A, E_FE2};
    tbl[8] = '{1'b0, 1'b1, 16'h2000, 8'h00, 8'h5A};

    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    for (int t = 0; t < 9; t++)
      do_access(tbl[t].wr, tbl[t].rd, tbl[t].a, tbl[t].wd, tbl[t].exp, 1'b0, $sformatf("tbl%0d", t));

    do_access(1'b0, 1'b1, 16'h1000, 8'h00, 8'h8E, 1'b1, "collide");

    // Reset in the middle of an access with the read strobe held high through release.
    @(negedge clk);
    addr = 16'h0102; oe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    lowc = 0; enc = 0;
    repeat (6) begin
      @(negedge clk);
      if (!rdy[0] || !rdy[1]) lowc++;
      if (en[0] || en[1]) enc++;
    end
    chk("midrst no_start_en", 32'(enc), 32'd0);
    chk("midrst no_start_rdy", 32'(lowc), 32'd0);
    chk("midrst dout_hold0", 32'(dout[0]), 32'h00);
    chk("midrst dout_hold1", 32'(dout[1]), 32'h00);
    oe = 1'b0;
    model_dout = 8'h00;
    do_access(1'b0, 1'b1, 16'h0102, 8'h00, exp_read(16'h0102), 1'b0, "after_rst");

    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 16'hFFFE + 16'($urandom_range(0, 1));
      else                           a = 16'h3000 + 16'($urandom_range(0, 15));
      wd = 8'($urandom);
      do_access(wr, !wr, a, wd, wr ? model_dout : exp_read(a), 1'b0, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_mem_bridge.md
Name: cpu_mem_bridge

Overview:
- Sits between the CPU core's strobe bus (cpu_addr_o/cpu_oe_o/cpu_we_o/cpu_data_o/cpu_data_i) and a synchronous single-port block RAM.
- Converts level read/write strobes into single-cycle RAM enables.
- Inserts programmable wait states, latches read data for the CPU and signals completion with a ready flag.
- Replaces the behavioural strobe-edge memory model for synthesis.

Parameters:
- ADDR_W, 16, RAM address width; ram_addr_o = cpu_addr_i[ADDR_W-1:0].
- WAIT_STATES, 0, extra cycles added to every access (0..15).
- RESET_VECTOR, 16'h1000, value returned at FFFE/FFFF when the overlay is enabled.

Ports:
- cpu_clk  in  1  clock; all state changes on rising edge.
- cpu_reset  in  1  reset, asynchronous, active-high.
- cpu_addr_i  in  16  CPU address.
- cpu_oe_i  in  1  read strobe, active-high.
- cpu_we_i  in  1  write strobe, active-high.
- cpu_data_i  in  8  write data from CPU.
- cpu_data_o  out  8  latched read data to CPU.
- cpu_ready_o  out  1  high when idle or access complete.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_en_o  out  1  RAM enable, one-cycle pulse.
- ram_we_o  out  1  RAM write enable, qualifies ram_en_o.
- ram_wdata_o  out  8  RAM write data.
- ram_rdata_i  in  8  RAM read data, valid the cycle after ram_en_o.

Behaviour:
- **Reset values:**
  - cpu_data_o=8'h00, cpu_ready_o=1, ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0.
  - FSM in IDLE; wait counter 0.
  - Strobe history registers oe_q=1, we_q=1, so a strobe held high across reset release does not start an access.
  - Reset asserted mid-access aborts immediately; no capture.
- **Start condition:** rising edge of a strobe, detected at clock edge E0 as strobe=1 and strobe_q=0.
  - oe_q and we_q update every cycle.
  - Both edges at the same E0: write wins; the read is dropped.
- **FSM states:** IDLE, ISSUE, WAIT, CAPTURE.
  - **IDLE:** on a start at E0, latch ram_addr_o and ram_wdata_o (from cpu_data_i). Assert ram_en_o, plus ram_we_o for a write. Drop cpu_ready_o. Load counter=WAIT_STATES. Go to ISSUE.
  - **ISSUE (1 cycle):** ram_en_o/ram_we_o deassert at the next edge. Go to WAIT if counter>0, else CAPTURE.
  - **WAIT:** decrement counter each cycle; go to CAPTURE when it reaches 1 (the counter loaded with N gives N cycles in WAIT).
  - **CAPTURE (1 cycle):** at the exit edge, E(2+WAIT_STATES):
    - For a read, cpu_data_o <= ram_rdata_i.
    - For a write, cpu_data_o is unchanged.
    - cpu_ready_o <= 1; return to IDLE.
- **Latency:** every access completes exactly 2+WAIT_STATES cycles after E0. cpu_ready_o is low for exactly that many cycles.
- **Read data hold:** cpu_data_o holds its value until the next read's capture.
- **Strobe edges while busy** (ISSUE/WAIT/CAPTURE): ignored, never queued. Edge history still updates, so a strobe held high across completion does not retrigger.
- **Address/data sampling:** address and write data are sampled only at E0; later changes during the access have no effect.
- **Address range:** addresses above 2^ADDR_W alias (upper bits dropped).

Optional Feature:
- Macro: VECTOR_OVERLAY_EN.
- **Defined:**
  - A read with cpu_addr_i==16'hFFFE captures RESET_VECTOR[15:8]; 16'hFFFF captures RESET_VECTOR[7:0].
  - Same FSM timing; ram_en_o stays 0 for these reads.
  - Writes to FFFE/FFFF still go to RAM.
- **Undefined:** FFFE/FFFF are plain RAM locations; no RESET_VECTOR logic is synthesised (the parameter remains but is unused).

Test Plan:
- Single read, WAIT_STATES=0, RAM[1000]=8E: oe rises at E0 with addr 1000 -> ram_en_o high for 1 cycle with ram_addr_o=1000, ram_we_o=0; cpu_ready_o low 2 cycles; cpu_data_o=8E at E2.
- Write, WAIT_STATES=3, we rises with addr 0102, data 01 -> ram_en_o=ram_we_o=1 for 1 cycle, ram_wdata_o=01; cpu_ready_o low 5 cycles; a subsequent read of 0102 returns 01; cpu_data_o is unchanged by the write.
- Overlay: with VECTOR_OVERLAY_EN defined and RESET_VECTOR=1000, reading FFFE then FFFF -> cpu_data_o=10 then 00, ram_en_o never asserted. Without the macro and RAM[FFFE]=A5 -> reads A5.
- Busy collision: WAIT_STATES=2, start a read of 1000; toggle we high during WAIT -> no second ram_en_o; one access completes at E4.
- Simultaneous oe and we rising at the same edge, addr 2000, data 5A -> single write of 5A to 2000, no read capture.
- Reset mid-access: assert cpu_reset during WAIT, hold oe high through release -> outputs at reset values, cpu_data_o=00, no access started after release until oe falls and rises again.
